led_pattern_engine: RTL and testbench
=====================================

Name: led_pattern_engine

Overview:
- Parametrised successor to the fixed shift/flash/mux LED path.
- One registered block that owns the tick prescaler and generates four selectable LED patterns: rotate, flash, bounce and binary count.
- Adds a programmable step rate and a pause input.
- Sits between board switches and the LED pins, driven directly from the board master clock.

Parameters:
- LED_WIDTH, 16, number of LED outputs; must be >= 2.
- TICK_DIV, 2500000, master-clock cycles per base tick (2 Hz at 5 MHz); must be >= 2.

Ports:
- CLK_5_MHZ  input  1  master clock; all logic on rising edge.
- CPU_RESETN  input  1  asynchronous active-low reset.
- mode  input  2  pattern select: 0 rotate, 1 flash, 2 bounce, 3 count.
- dir  input  1  rotate direction: 0 toward MSB, 1 toward LSB. Ignored in other modes.
- speed  input  2  step occurs every 2^speed base ticks (1, 2, 4, 8).
- pause  input  1  1 freezes prescaler, step counter and pattern.
- led  output  LED_WIDTH  registered pattern output.
- step  output  1  one-cycle pulse in the cycle led takes a new stepped value.

Behaviour:
- Reset (CPU_RESETN=0, asynchronous):
  - led=0, step=0, prescaler=0, tick counter=0, bounce direction=up.
  - load_pending=1, mode_q=0.
- Load:
  - Occurs on the first rising edge with reset deasserted, or on any edge where mode != mode_q.
  - Actions: led <= INIT(mode), mode_q <= mode, prescaler=0, tick counter=0, bounce direction=up, load_pending=0, step=0.
  - Load has priority over stepping and over pause.
- INIT values: rotate = one-hot bit0; flash = all ones; bounce = one-hot bit0; count = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while pause=0.
  - base tick is a one-cycle internal pulse when the count equals TICK_DIV-1; the count then wraps to 0.
  - While pause=1, holds its value and produces no tick.
- Tick counter (3 bits):
  - On a base tick: if counter >= 2^speed-1, issue a step and clear the counter; otherwise increment.
  - A speed change takes effect at the next tick. If the counter already exceeds the new threshold, the next tick steps.
- Step, applied at the same edge that asserts the step output:
  - Rotate, dir=0: led <= {led[W-2:0], led[W-1]}.
  - Rotate, dir=1: led <= {led[0], led[W-1:1]}.
  - A dir change applies to the next step with no reload.
  - Flash: led <= ~led, alternating all ones and all zeros.
  - Bounce: one-hot moves toward MSB while direction=up. On reaching bit W-1, direction becomes down and the next step gives bit W-2. Reaching bit0 flips direction back to up.
  - Bounce sequence for W=4: 1,2,4,8,4,2,1,2... The endpoints are never held for two steps.
  - Count: led <= led+1 modulo 2^LED_WIDTH; all ones wraps to 0.
- Latency:
  - led changes exactly at the edge where step=1.
  - From a load, the first step occurs after (2^speed)*TICK_DIV cycles of unpaused operation.
- Pause:
  - Blocks ticks and steps only; mode changes still load.
  - Releasing pause resumes the prescaler from its held count.
- Reset mid-operation: returns all state to reset values immediately, independent of the clock.
- Only values reachable from INIT are produced; there are no X or illegal states.

Test Plan:
- Reset, LED_WIDTH=8, TICK_DIV=4, speed=0, mode=0, dir=0, release reset -> led=0x00, then 0x01 at the first edge. Steps every 4 cycles: 0x02, 0x04 ... 0x80, 0x01. Step pulse is 1 cycle wide.
- Rotate, dir switched to 1 while led=0x10 -> next step gives 0x08; from 0x01 the next step gives 0x80. No reload when dir changes.
- mode=2, W=8 -> led sequence 0x01,0x02,...,0x80,0x40,...,0x01,0x02. mode=1 -> 0xFF,0x00,0xFF.
- mode=3, speed=2 -> step every 16 cycles, led 0x00,0x01,0x02. Force led to 0xFF via 255 steps; the next step gives 0x00.
- pause=1 for 20 cycles mid-prescale -> led, prescaler and step all frozen. Changing mode to 1 while paused -> led=0xFF next edge with no steps. Release pause -> first step after 4 cycles.
- Mode change in the same cycle as a due step -> load wins: led=INIT, step=0. Assert CPU_RESETN=0 between clock edges -> led=0 immediately, then INIT(mode) on the first edge after release.

Source files
------------

// File: rtl/led_pattern_engine.sv
// led_pattern_engine
// Registered LED pattern generator with its own tick prescaler. Produces
// rotate, flash, bounce and binary-count patterns at a programmable step
// rate, with a pause input that freezes all timing and pattern state.
module led_pattern_engine #(
  parameter int LED_WIDTH = 16,
  parameter int TICK_DIV  = 2500000
) (
  input  logic                 CLK_5_MHZ,
  input  logic                 CPU_RESETN,
  input  logic [1:0]           mode,
  input  logic                 dir,
  input  logic [1:0]           speed,
  input  logic                 pause,
  output logic [LED_WIDTH-1:0] led,
  output logic                 step
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_ROTATE = 2'd0;
  localparam logic [1:0] MODE_FLASH  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 step_q, step_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [2:0]           tick_cnt_q, tick_cnt_d;
  logic                 bounce_up_q, bounce_up_d;
  logic                 load_pending_q, load_pending_d;
  logic [1:0]           mode_q, mode_d;

  logic                 load;
  logic                 base_tick;
  logic [2:0]           tick_limit;
  logic [LED_WIDTH-1:0] led_next;
  logic                 bounce_up_next;

  // Starting pattern each mode begins from after a load
  function automatic logic [LED_WIDTH-1:0] init_pattern(input logic [1:0] m);
    case (m)
      MODE_FLASH: init_pattern = {LED_WIDTH{1'b1}};
      MODE_COUNT: init_pattern = '0;
      default:    init_pattern = {{(LED_WIDTH-1){1'b0}}, 1'b1};
    endcase
  endfunction

  // Next stepped pattern for the active mode, plus the bounce direction update
  always_comb begin
    led_next       = led_q;
    bounce_up_next = bounce_up_q;
    case (mode_q)
      MODE_ROTATE: begin
        if (dir) led_next = {led_q[0], led_q[LED_WIDTH-1:1]};
        else     led_next = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
      end
      MODE_FLASH: led_next = ~led_q;
      MODE_BOUNCE: begin
        if (bounce_up_q) begin
          led_next = led_q << 1;
          if (led_q[LED_WIDTH-2]) bounce_up_next = 1'b0;
        end else begin
          led_next = led_q >> 1;
          if (led_q[1]) bounce_up_next = 1'b1;
        end
      end
      default: led_next = led_q + 1'b1;
    endcase
  end

  // Load / prescaler / tick counter / step sequencing; load beats pause and step
  always_comb begin
    led_d          = led_q;
    step_d         = 1'b0;
    presc_d        = presc_q;
    tick_cnt_d     = tick_cnt_q;
    bounce_up_d    = bounce_up_q;
    load_pending_d = load_pending_q;
    mode_d         = mode_q;

    load      = load_pending_q || (mode != mode_q);
    base_tick = !pause && (presc_q == PRESC_MAX);

    case (speed)
      2'd0:    tick_limit = 3'd0;
      2'd1:    tick_limit = 3'd1;
      2'd2:    tick_limit = 3'd3;
      default: tick_limit = 3'd7;
    endcase

    if (load) begin
      led_d          = init_pattern(mode);
      mode_d         = mode;
      presc_d        = '0;
      tick_cnt_d     = '0;
      bounce_up_d    = 1'b1;
      load_pending_d = 1'b0;
    end else if (!pause) begin
      if (base_tick) begin
        presc_d = '0;
        if (tick_cnt_q >= tick_limit) begin
          tick_cnt_d  = '0;
          step_d      = 1'b1;
          led_d       = led_next;
          bounce_up_d = bounce_up_next;
        end else begin
          tick_cnt_d = tick_cnt_q + 3'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK_5_MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      led_q          <= '0;
      step_q         <= 1'b0;
      presc_q        <= '0;
      tick_cnt_q     <= '0;
      bounce_up_q    <= 1'b1;
      load_pending_q <= 1'b1;
      mode_q         <= MODE_ROTATE;
    end else begin
      led_q          <= led_d;
      step_q         <= step_d;
      presc_q        <= presc_d;
      tick_cnt_q     <= tick_cnt_d;
      bounce_up_q    <= bounce_up_d;
      load_pending_q <= load_pending_d;
      mode_q         <= mode_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed testbench for led_pattern_engine with LED_WIDTH=8, TICK_DIV=4.
// Expected values are hand-computed constants from the pattern definitions.
module tb_led_pattern_engine;

  localparam int W   = 8;
  localparam int DIV = 4;

  logic         clk;
  logic         resetN;
  logic [1:0]   mode;
  logic         dir;
  logic [1:0]   speed;
  logic         pause;
  logic [W-1:0] led;
  logic         step;

  int checkCount;
  int passCount;

  led_pattern_engine #(.LED_WIDTH(W), .TICK_DIV(DIV)) dut (
    .CLK_5_MHZ  (clk),
    .CPU_RESETN (resetN),
    .mode       (mode),
    .dir        (dir),
    .speed      (speed),
    .pause      (pause),
    .led        (led),
    .step       (step)
  );

  // Free-running master clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Advance n rising edges and settle just after the last one
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect one step exactly 'period' edges from now, quiet before it
  task automatic stepCheck(input string tag, input logic [W-1:0] expLed, input int period);
    applyStimulus(1);
    checkOutput({tag, "_quiet"}, {31'd0, step}, 32'd0);
    if (period > 2) applyStimulus(period - 2);
    applyStimulus(1);
    checkOutput({tag, "_step"}, {31'd0, step}, 32'd1);
    checkOutput({tag, "_led"}, {24'd0, led}, {24'd0, expLed});
  endtask

  logic [W-1:0] rotUp   [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [W-1:0] bounceSeq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [W-1:0] rotDown [5]  = '{8'h08, 8'h04, 8'h02, 8'h01, 8'h80};

  initial begin
    checkCount = 0;
    passCount  = 0;
    resetN = 1'b0;
    mode   = 2'd0;
    dir    = 1'b0;
    speed  = 2'd0;
    pause  = 1'b0;

    // Reset state
    applyStimulus(2);
    checkOutput("reset_led", {24'd0, led}, 32'h00);
    checkOutput("reset_step", {31'd0, step}, 32'd0);

    // First edge after release loads rotate INIT
    resetN = 1'b1;
    applyStimulus(1);
    checkOutput("load_rotate_led", {24'd0, led}, 32'h01);
    checkOutput("load_rotate_step", {31'd0, step}, 32'd0);

    // Rotate toward MSB, wrapping back to bit0
    for (int i = 0; i < 8; i++) stepCheck($sformatf("rot_up%0d", i), rotUp[i], DIV);

    // Walk to 0x10, then reverse direction without reload
    for (int i = 0; i < 4; i++) stepCheck($sformatf("rot_pre%0d", i), rotUp[i], DIV);
    dir = 1'b1;
    for (int i = 0; i < 5; i++) stepCheck($sformatf("rot_dn%0d", i), rotDown[i], DIV);
    dir = 1'b0;

    // Bounce
    mode = 2'd2;
    applyStimulus(1);
    checkOutput("load_bounce_led", {24'd0, led}, 32'h01);
    checkOutput("load_bounce_step", {31'd0, step}, 32'd0);
    for (int i = 0; i < 15; i++) stepCheck($sformatf("bounce%0d", i), bounceSeq[i], DIV);

    // Flash
    mode = 2'd1;
    applyStimulus(1);
    checkOutput("load_flash_led", {24'd0, led}, 32'hFF);
    stepCheck("flash0", 8'h00, DIV);
    stepCheck("flash1", 8'hFF, DIV);

    // Speed 3 accumulates counter to 5, switching to speed 1 steps on next tick
    speed = 2'd3;
    applyStimulus(20);
    checkOutput("slow_hold_led", {24'd0, led}, 32'hFF);
    speed = 2'd1;
    applyStimulus(3);
    checkOutput("spd_drop_quiet", {31'd0, step}, 32'd0);
    applyStimulus(1);
    checkOutput("spd_drop_step", {31'd0, step}, 32'd1);
    checkOutput("spd_drop_led", {24'd0, led}, 32'h00);
    stepCheck("speed1", 8'hFF, 2 * DIV);

    // Count at speed 2: step every 16 cycles
    mode  = 2'd3;
    speed = 2'd2;
    applyStimulus(1);
    checkOutput("load_count_led", {24'd0, led}, 32'h00);
    stepCheck("count1", 8'h01, 4 * DIV);
    stepCheck("count2", 8'h02, 4 * DIV);

    // Run to all ones at speed 0, then wrap
    speed = 2'd0;
    applyStimulus(252 * DIV);
    checkOutput("count_fe", {24'd0, led}, 32'hFE);
    stepCheck("count_ff", 8'hFF, DIV);
    stepCheck("count_wrap", 8'h00, DIV);

    // Pause mid-prescale freezes everything; resume from held count
    applyStimulus(2);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("pause_led%0d", i), {24'd0, led}, 32'h00);
      checkOutput($sformatf("pause_step%0d", i), {31'd0, step}, 32'd0);
    end
    pause = 1'b0;
    applyStimulus(1);
    checkOutput("resume_quiet", {31'd0, step}, 32'd0);
    applyStimulus(1);
    checkOutput("resume_step", {31'd0, step}, 32'd1);
    checkOutput("resume_led", {24'd0, led}, 32'h01);

    // Mode change while paused still loads; no steps until released
    applyStimulus(1);
    pause = 1'b1;
    mode  = 2'd1;
    applyStimulus(1);
    checkOutput("pause_load_led", {24'd0, led}, 32'hFF);
    applyStimulus(10);
    checkOutput("pause_load_hold", {24'd0, led}, 32'hFF);
    checkOutput("pause_load_step", {31'd0, step}, 32'd0);
    pause = 1'b0;
    stepCheck("pause_release", 8'h00, DIV);

    // Mode change on the edge a step is due: load wins
    applyStimulus(3);
    mode = 2'd0;
    applyStimulus(1);
    checkOutput("collide_led", {24'd0, led}, 32'h01);
    checkOutput("collide_step", {31'd0, step}, 32'd0);
    stepCheck("collide_next", 8'h02, DIV);

    // Asynchronous reset between edges, then reload of current mode
    applyStimulus(1);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("async_reset_led", {24'd0, led}, 32'h00);
    checkOutput("async_reset_step", {31'd0, step}, 32'd0);
    mode = 2'd1;
    applyStimulus(2);
    checkOutput("async_hold_led", {24'd0, led}, 32'h00);
    resetN = 1'b1;
    applyStimulus(1);
    checkOutput("reload_led", {24'd0, led}, 32'hFF);
    stepCheck("reload_next", 8'h00, DIV);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
